// File: rtl/axis_seq_checker.sv
// axis_seq_checker: in-line AXI4-Stream framing checker.
//
// Forwards every beat unchanged through a 2-entry skid buffer (registered outputs) and checks
// each accepted input beat: packets must be PKT_BEATS long with TLAST on the final beat, and the
// top byte of TDATA must equal the beat index. Checks never stall or alter the stream.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast     input stream
//   s_axis_tready                 input ready (registered, equals "skid entry empty")
//   m_axis_tdata/tvalid/tlast     forwarded stream
//   m_axis_tready                 output ready
//   pkt_count                     accepted TLAST beats, wraps
//   err_count                     erroneous beats, saturates at all-ones
//   err_seq, err_len              one-cycle error pulses, the cycle after the offending accept
//   in_packet                     high while the checker is inside a packet (ACTIVE or OVERRUN)
module axis_seq_checker #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned PKT_BEATS   = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic                   err_seq,
  output logic                   err_len,
  output logic                   in_packet
);

  localparam logic [7:0] LastIdx = 8'(PKT_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StActive, StOverrun} state_e;

  // Skid buffer: output register plus one skid entry.
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic                   ready_q;
  logic                   accept, out_free;

  // Checker state.
  state_e                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [7:0]             seq;
  logic                   seq_err, len_err;
  logic                   err_seq_q, err_len_q;
  logic [CNT_WIDTH-1:0]   pkt_q, pkt_d, err_q, err_d;

  assign accept   = s_axis_tvalid & ready_q;
  assign out_free = ~out_valid_q | m_axis_tready;
  assign seq      = s_axis_tdata[TDATA_WIDTH-1 -: 8];

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // ready_q is low while the skid entry is full, so no accept can collide here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = s_axis_tdata;
          out_last_d = s_axis_tlast;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_last_d  = s_axis_tlast;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_err = 1'b0;
    len_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          seq_err = (seq != 8'd0);
          if (s_axis_tlast) begin
            len_err = 1'b1;  // a one-beat packet is always too short
          end else begin
            state_d = StActive;
            idx_d   = 8'd1;
          end
        end
        StActive: begin
          seq_err = (seq != idx_q);
          if (s_axis_tlast) begin
            len_err = (idx_q != LastIdx);
            state_d = StIdle;
            idx_d   = 8'd0;
          end else if (idx_q == LastIdx) begin
            len_err = 1'b1;
            state_d = StOverrun;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        StOverrun: begin
          if (s_axis_tlast) begin
            state_d = StIdle;
            idx_d   = 8'd0;
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    err_d = err_q;
    if (accept && s_axis_tlast) begin
      pkt_d = pkt_q + CNT_WIDTH'(1);
    end
    // One increment per offending beat, even when both checks fail.
    if ((seq_err || len_err) && (err_q != '1)) begin
      err_d = err_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
      state_q      <= StIdle;
      idx_q        <= 8'd0;
      err_seq_q    <= 1'b0;
      err_len_q    <= 1'b0;
      pkt_q        <= '0;
      err_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      ready_q      <= ~skid_valid_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_seq_q    <= seq_err;
      err_len_q    <= len_err;
      pkt_q        <= pkt_d;
      err_q        <= err_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign pkt_count     = pkt_q;
  assign err_count     = err_q;
  assign err_seq       = err_seq_q;
  assign err_len       = err_len_q;
  assign in_packet     = (state_q != StIdle);

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- AXI4-Stream in-line checker for the PCPIP test datapath.
- Sits directly downstream of the stream master and upstream of the stream slave.
- Forwards every beat unchanged through a 2-entry skid buffer and checks packet framing: fixed beat count with TLAST on the final beat, and a sequence byte in the top byte of TDATA equal to the beat index.
- Exposes packet and error counters plus one-cycle error pulses for the bench and for debug.

Parameters:
- TDATA_WIDTH, 64, stream data width in bits; multiple of 8, at least 16.
- PKT_BEATS, 8, expected beats per packet; range 2..256.
- CNT_WIDTH, 16, width of pkt_count and err_count.

Ports:
- aclk  in  1  single clock; all logic is rising-edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  TDATA_WIDTH  input stream data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  forwarded data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  forwarded end-of-packet.
- m_axis_tready  in  1  output ready.
- pkt_count  out  CNT_WIDTH  packets completed (TLAST accepted); wraps.
- err_count  out  CNT_WIDTH  erroneous beats; saturates at all-ones.
- err_seq  out  1  one-cycle pulse: sequence mismatch.
- err_len  out  1  one-cycle pulse: length violation.
- in_packet  out  1  high while the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset state: all outputs 0, skid buffer empty, FSM in IDLE, beat index 0.
  - s_axis_tready is 0 while areset is high and goes to 1 on the first clock after release.
  - Reset mid-packet discards buffered beats and partial-packet state without raising any error.
- Accept and forward: an input beat is accepted when s_axis_tvalid and s_axis_tready are both 1. An output beat transfers when m_axis_tvalid and m_axis_tready are both 1.
- Skid buffer: 2 entries, registered outputs.
  - A beat accepted in cycle N is presented on m_axis in cycle N+1 when the output register is empty or draining.
  - s_axis_tready is registered and equals "skid entry empty".
  - Sustains full throughput when m_axis_tready is held 1.
  - m_axis_tvalid, m_axis_tdata and m_axis_tlast hold stable while stalled.
  - No beat is lost, duplicated or reordered.
- Check inputs: the checker acts only on accepted input beats. seq = s_axis_tdata[TDATA_WIDTH-1 -: 8]. idx is an 8-bit beat index.
- FSM, IDLE:
  - An accepted beat is checked as idx 0.
  - Without TLAST: go to ACTIVE with idx=1.
  - With TLAST: PKT_BEATS is at least 2, so err_len is raised; pkt_count increments and the FSM stays in IDLE.
- FSM, ACTIVE:
  - Each accepted beat is checked against idx.
  - TLAST with idx != PKT_BEATS-1: err_len; go to IDLE.
  - TLAST with idx == PKT_BEATS-1: go to IDLE, no length error.
  - No TLAST with idx == PKT_BEATS-1: err_len; go to OVERRUN.
  - Otherwise idx increments.
- FSM, OVERRUN: beats are forwarded with no sequence check and no further err_len. The FSM returns to IDLE on TLAST.
- Sequence check (IDLE and ACTIVE only): seq != idx raises err_seq.
- Error pulse timing:
  - err_seq and err_len assert in the cycle after the offending accept, for exactly one cycle.
  - Both may assert together.
- Counters:
  - err_count increments by 1 per offending beat, even when both errors occur on that beat, and saturates at all-ones.
  - pkt_count increments by 1 on every accepted TLAST, in any state, and wraps modulo 2^CNT_WIDTH.
  - Both counters update in the same cycle as the error pulses.
- in_packet is 1 in ACTIVE and OVERRUN.
- Pass-through independence: data forwarding is unaffected by check results. Errors never stall or drop beats.

Test Plan:
- Clean packet: 8 beats, top byte 0x00..0x07 with other bytes zero, TLAST on beat 8, m_axis_tready held 1 -> 8 identical output beats, each 1 cycle after its accept; TLAST on beat 8 only; pkt_count=1, err_count=0, no pulses.
- Backpressure: 4 clean packets; m_axis_tready low 2 cycles / high 6 cycles; random s_axis_tvalid -> output stream matches input exactly, in order; pkt_count=4, err_count=0; s_axis_tready deasserts only when the skid entry is full.
- Sequence error: packet with beat 3 top byte 0x05 -> single err_seq pulse the cycle after beat 3 is accepted; err_count=1, pkt_count=1, err_len never asserted.
- Short packet: TLAST on beat 5, then a clean 8-beat packet -> err_len pulse after beat 5; second packet checked from idx 0 with no error; pkt_count=2, err_count=1.
- Long packet: 10 beats with top byte = index, TLAST on beat 10 -> one err_len pulse after beat 8 (idx 7, no TLAST); in_packet held through beat 10; pkt_count=1, err_count=1; all 10 beats forwarded.
- Reset mid-packet and saturation: areset for 1 cycle after 4 beats -> counters 0, m_axis_tvalid 0, s_axis_tready 0 during reset and 1 the next cycle; following clean packet gives no error. Separately, with CNT_WIDTH=2, 5 erroneous beats -> err_count=3.
